// File: rtl/shift_register_univ.sv
// Universal N-bit shift register: parallel load, or shift/rotate by `amount` at one 1-bit step per falling edge.
// Latency: load 1 edge, command amount+1 edges to done; no backpressure, load/start are ignored while busy.
module shift_register_univ #(
    parameter int N  = 8,
    parameter int CW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [N-1:0]  I,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [CW-1:0] amount,
    input  logic          si,
    output logic [N-1:0]  O,
    output logic          so,
    output logic          busy,
    output logic          done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state;
    logic [2:0]    mode_q;
    logic [CW-1:0] cnt;
    logic [N-1:0]  nxt_o;
    logic          nxt_so;

    // One step of the captured operation; reserved codes fall through to hold.
    always_comb begin
        nxt_o  = O;
        nxt_so = so;
        case (mode_q)
            3'b001: begin nxt_o = {O[N-2:0], si};     nxt_so = O[N-1]; end
            3'b010: begin nxt_o = {si, O[N-1:1]};     nxt_so = O[0];   end
            3'b011: begin nxt_o = {O[N-2:0], O[N-1]}; nxt_so = O[N-1]; end
            3'b100: begin nxt_o = {O[0], O[N-1:1]};   nxt_so = O[0];   end
            3'b101: begin nxt_o = {O[N-1], O[N-1:1]}; nxt_so = O[0];   end
            default: begin nxt_o = O;                 nxt_so = so;     end
        endcase
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            mode_q <= 3'b000;
            cnt    <= '0;
            O      <= '0;
            so     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        O <= I;
                    end else if (start) begin
                        if (amount == '0) begin
                            done <= 1'b1;
                        end else begin
                            mode_q <= mode;
                            cnt    <= amount;
                            busy   <= 1'b1;
                            state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    O   <= nxt_o;
                    so  <= nxt_so;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_register_univ.sv
// Scoreboard bench for shift_register_univ: each command pushes its expected final state,
// a monitor pops and compares on every done pulse.
module tb_shift_register_univ;

    localparam int N  = 8;
    localparam int CW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load;
    logic [N-1:0]  I;
    logic          start;
    logic [2:0]    mode;
    logic [CW-1:0] amount;
    logic          si;
    logic [N-1:0]  O;
    logic          so;
    logic          busy;
    logic          done;

    typedef struct {
        logic [N-1:0] o;
        logic         so;
        int           busy_n;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_run = 0;

    shift_register_univ #(.N(N), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .I(I), .start(start),
        .mode(mode), .amount(amount), .si(si), .O(O), .so(so),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the non-active (rising) edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                busy_run = 0;
            end else begin
                if (busy) busy_run++;
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_O", 32'(O), 32'(e.o));
                        chk("done_so", 32'(so), 32'(e.so));
                        chk("busy_cycles", 32'(busy_run), 32'(e.busy_n));
                        chk("busy_at_done", 32'(busy), 32'd0);
                    end
                    busy_run = 0;
                end
            end
        end
    end

    task automatic do_load(input logic [N-1:0] v);
        @(negedge clk); #1;
        load = 1'b1; I = v;
        @(negedge clk); #1;
        load = 1'b0;
        @(posedge clk);
        chk("load_O", 32'(O), 32'(v));
    endtask

    task automatic do_cmd(input logic [2:0] m, input int a, input logic [15:0] si_seq,
                          input logic inj_load, input logic [N-1:0] e_o,
                          input logic e_so, input string name);
        exp_t e;
        e.o = e_o; e.so = e_so; e.busy_n = a;
        sb.push_back(e);
        @(negedge clk); #1;
        start = 1'b1; mode = m; amount = CW'(a);
        @(negedge clk); #1;
        start = 1'b0; mode = 3'b111; amount = '1;
        for (int i = 0; i < a; i++) begin
            si = si_seq[i];
            load = inj_load; I = 8'hFF;
            @(negedge clk); #1;
        end
        load = 1'b0; si = 1'b0;
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            chk({"timeout_", name}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        reset_n = 1'b0; load = 1'b0; I = '0; start = 1'b0;
        mode = 3'b000; amount = '0; si = 1'b0;
        #2;
        chk("rst_O", 32'(O), 32'd0);
        chk("rst_so", 32'(so), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        #10 reset_n = 1'b1;

        do_load(8'h81);
        do_cmd(3'b011, 3, 16'h0, 1'b0, 8'h0C, 1'b0, "rol3");
        do_load(8'hF0);
        do_cmd(3'b010, 4, 16'hD, 1'b0, 8'hDF, 1'b0, "shr4_si");
        do_load(8'h90);
        do_cmd(3'b101, 2, 16'h0, 1'b0, 8'hE4, 1'b0, "asr2");
        do_cmd(3'b001, 0, 16'h0, 1'b0, 8'hE4, 1'b0, "amount0");
        do_load(8'h01);
        do_cmd(3'b100, 9, 16'h0, 1'b0, 8'h80, 1'b1, "ror9");
        do_cmd(3'b110, 2, 16'h0, 1'b0, 8'h80, 1'b1, "mode110");
        do_load(8'h81);
        do_cmd(3'b011, 3, 16'h0, 1'b1, 8'h0C, 1'b0, "rol3_load_ignored");

        // Load and start together in IDLE: load wins, no command starts.
        @(negedge clk); #1;
        load = 1'b1; I = 8'hFF; start = 1'b1; mode = 3'b011; amount = CW'(3);
        @(negedge clk); #1;
        load = 1'b0; start = 1'b0;
        @(posedge clk);
        chk("collide_O", 32'(O), 32'hFF);
        chk("collide_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        chk("collide_so", 32'(so), 32'd0);

        // Asynchronous reset in the middle of a ROL by 5.
        do_load(8'hA5);
        @(negedge clk); #1;
        start = 1'b1; mode = 3'b011; amount = CW'(5);
        @(negedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        chk("mid_O", 32'(O), 32'h4B);
        chk("mid_so", 32'(so), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_O", 32'(O), 32'd0);
        chk("abort_so", 32'(so), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        chk("abort_still_idle", 32'(busy), 32'd0);
        chk("leftover_expect", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
